// File: rtl/mem_arbiter.sv
// Shares one memory port between ICache refills and DCache accesses.
// D wins ties unless I has been passed over STARVE_MAX times; BUSY aborts after TIMEOUT cycles.
module mem_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [DATA_W-1:0] i_addr,
    output logic              i_done,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef struct packed {
        logic              we;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    state_t            state, state_nxt;
    owner_t            owner, owner_nxt;
    cmd_t              cmd, cmd_nxt;
    logic              mem_req_r, mem_req_nxt;
    logic              i_done_r, i_done_nxt;
    logic              d_done_r, d_done_nxt;
    logic              err_r, err_nxt;
    logic [DATA_W-1:0] i_rdata_r, i_rdata_nxt;
    logic [DATA_W-1:0] d_rdata_r, d_rdata_nxt;
    logic [SW-1:0]     starve, starve_nxt;
    logic [TW-1:0]     tcnt, tcnt_nxt;

    logic              grant_i;
    logic [DATA_W-1:0] rsp_data;

    // I wins only when alone or when it has been starved long enough
    assign grant_i  = i_req && (!d_req || (starve == SW'(STARVE_MAX)));
    assign rsp_data = cmd.we ? '0 : mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_I;
            cmd       <= '0;
            mem_req_r <= 1'b0;
            i_done_r  <= 1'b0;
            d_done_r  <= 1'b0;
            err_r     <= 1'b0;
            i_rdata_r <= '0;
            d_rdata_r <= '0;
            starve    <= '0;
            tcnt      <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            cmd       <= cmd_nxt;
            mem_req_r <= mem_req_nxt;
            i_done_r  <= i_done_nxt;
            d_done_r  <= d_done_nxt;
            err_r     <= err_nxt;
            i_rdata_r <= i_rdata_nxt;
            d_rdata_r <= d_rdata_nxt;
            starve    <= starve_nxt;
            tcnt      <= tcnt_nxt;
        end
    end

    // Next-state and registered-output logic; done/err/rdata default to a one-cycle pulse
    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        cmd_nxt     = cmd;
        mem_req_nxt = mem_req_r;
        i_done_nxt  = 1'b0;
        d_done_nxt  = 1'b0;
        err_nxt     = 1'b0;
        i_rdata_nxt = '0;
        d_rdata_nxt = '0;
        starve_nxt  = starve;
        tcnt_nxt    = tcnt;

        case (state)
            IDLE: begin
                if (i_req || d_req) begin
                    state_nxt   = BUSY;
                    mem_req_nxt = 1'b1;
                    tcnt_nxt    = '0;
                    if (grant_i) begin
                        owner_nxt     = OWN_I;
                        cmd_nxt.we    = 1'b0;
                        cmd_nxt.addr  = i_addr;
                        cmd_nxt.wdata = '0;
                        starve_nxt    = '0;
                    end else begin
                        owner_nxt     = OWN_D;
                        cmd_nxt.we    = d_we;
                        cmd_nxt.addr  = d_addr;
                        cmd_nxt.wdata = d_wdata;
                        if (!i_req) begin
                            starve_nxt = '0;
                        end else if (starve != SW'(STARVE_MAX)) begin
                            starve_nxt = starve + SW'(1);
                        end
                    end
                end
            end

            BUSY: begin
                // A completion arriving on the last allowed cycle beats the timeout
                if (mem_ready) begin
                    state_nxt   = DONE;
                    mem_req_nxt = 1'b0;
                    cmd_nxt.we  = 1'b0;
                    if (owner == OWN_I) begin
                        i_done_nxt  = 1'b1;
                        i_rdata_nxt = rsp_data;
                    end else begin
                        d_done_nxt  = 1'b1;
                        d_rdata_nxt = rsp_data;
                    end
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    state_nxt   = DONE;
                    mem_req_nxt = 1'b0;
                    cmd_nxt.we  = 1'b0;
                    err_nxt     = 1'b1;
                    tcnt_nxt    = tcnt + TW'(1);
                    if (owner == OWN_I) begin
                        i_done_nxt = 1'b1;
                    end else begin
                        d_done_nxt = 1'b1;
                    end
                end else begin
                    tcnt_nxt = tcnt + TW'(1);
                end
            end

            DONE: begin
                state_nxt = IDLE;
                tcnt_nxt  = '0;
            end

            default: begin
                state_nxt   = IDLE;
                mem_req_nxt = 1'b0;
            end
        endcase
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = cmd.we;
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;
    assign i_done    = i_done_r;
    assign d_done    = d_done_r;
    assign err       = err_r;
    assign i_rdata   = i_rdata_r;
    assign d_rdata   = d_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Random bench for mem_arbiter: each transaction is predicted by a transaction-level model
// (grant choice from a plain integer starvation count, expected data/err from the memory responder).
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned DATA_W     = 32;
    localparam int          STARVE_MAX = 4;
    localparam int          TIMEOUT    = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_req = 1'b0;
    logic [DATA_W-1:0] i_addr = '0;
    logic              i_done;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [DATA_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_done;
    logic [DATA_W-1:0] d_rdata;
    logic              err;
    logic              mem_req;
    logic              mem_we;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic              mem_ready = 1'b0;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          starve_m = 0;
    bit          use_force = 1'b0;
    logic [31:0] force_rdata = '0;

    mem_arbiter #(
        .DATA_W    (DATA_W),
        .STARVE_MAX(STARVE_MAX),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_done   (i_done),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_done   (d_done),
        .d_rdata  (d_rdata),
        .err      (err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_mem_req"}, mem_req, 1'b0);
        check({tag, "_i_done"}, i_done, 1'b0);
        check({tag, "_d_done"}, d_done, 1'b0);
        check({tag, "_err"}, err, 1'b0);
        check({tag, "_i_rdata"}, i_rdata, '0);
        check({tag, "_d_rdata"}, d_rdata, '0);
    endtask

    // Called at the falling edge of an IDLE cycle with at least one request up.
    // lat = BUSY cycles before mem_ready (>= TIMEOUT means never); again = winner re-requests.
    task automatic run_txn(input int lat, input bit again, input bit rnd, output bit got_i);
        bit          own_i;
        bit          e_we;
        bit          e_err;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] e_rdata;

        own_i = i_req && (!d_req || starve_m == STARVE_MAX);
        if (own_i) begin
            e_addr = i_addr; e_we = 1'b0; e_wdata = '0;
            starve_m = 0;
        end else begin
            e_addr = d_addr; e_we = d_we; e_wdata = d_wdata;
            if (!i_req) starve_m = 0;
            else if (starve_m < STARVE_MAX) starve_m++;
        end
        step();

        // disturb the winner's inputs: the latched command must not follow them
        if (own_i) begin
            i_addr = $urandom;
        end else begin
            d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
        end
        if (rnd && !i_req && $urandom_range(0, 1) == 1) begin
            i_req = 1'b1; i_addr = $urandom;
        end
        if (rnd && !d_req && $urandom_range(0, 1) == 1) begin
            d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
        end

        e_rdata = '0;
        e_err   = 1'b1;
        for (int k = 0; k < TIMEOUT; k++) begin
            mem_rdata = use_force ? force_rdata : $urandom;
            mem_ready = (k == lat);
            if (k == lat) begin
                e_err   = 1'b0;
                e_rdata = e_we ? '0 : mem_rdata;
            end
            check("busy_mem_req", mem_req, 1'b1);
            check("busy_mem_addr", mem_addr, e_addr);
            check("busy_mem_we", mem_we, e_we);
            check("busy_mem_wdata", mem_wdata, e_wdata);
            check("busy_no_done", {i_done, d_done}, '0);
            step();
            if (k == lat) break;
        end

        mem_ready = 1'b0;
        got_i = i_done;
        check("done_i", i_done, own_i);
        check("done_d", d_done, !own_i);
        check("done_err", err, e_err);
        check("done_mem_req", mem_req, 1'b0);
        check("done_rdata", own_i ? i_rdata : d_rdata, e_rdata);
        check("done_other_rdata", own_i ? d_rdata : i_rdata, '0);

        if (own_i) begin
            i_req = again; i_addr = $urandom;
        end else begin
            d_req = again; d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
        end
        // a completion strobe during DONE must be ignored
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        step();
        mem_ready = 1'b0;
        check_idle("post_done");
    endtask

    initial begin
        bit   g;
        bit   exp_seq [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        int   lat;
        int   sel;

        // reset values
        step();
        step();
        check_idle("reset");
        check("reset_mem_we", mem_we, 1'b0);
        check("reset_mem_addr", mem_addr, '0);
        check("reset_mem_wdata", mem_wdata, '0);
        rst = 1'b0;
        step();

        // single I refill, minimum latency, fixed read data
        i_req = 1'b1; i_addr = 32'h100;
        use_force = 1'b1; force_rdata = 32'hDEADBEEF;
        run_txn(0, 1'b0, 1'b0, g);
        use_force = 1'b0;
        check("i_only_grant", g, 1'b1);

        // simultaneous: D write first, then I
        i_req = 1'b1; i_addr = 32'h400;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'h55;
        run_txn(0, 1'b0, 1'b0, g);
        check("both_first_is_d", g, 1'b0);
        run_txn(1, 1'b0, 1'b0, g);
        check("both_then_i", g, 1'b1);

        // starvation: four D wins, then I, then D again with counter cleared
        i_req = 1'b1; i_addr = $urandom;
        d_req = 1'b1; d_we = 1'b0; d_addr = $urandom;
        for (int n = 0; n < 6; n++) begin
            run_txn(n % 3, 1'b1, 1'b0, g);
            check("starve_seq", g, exp_seq[n]);
        end
        for (int n = 0; n < 4 && (i_req || d_req); n++) run_txn(0, 1'b0, 1'b0, g);

        // timeout on a D read, and ready colliding with the last timeout cycle
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000;
        run_txn(1000, 1'b0, 1'b0, g);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3004;
        run_txn(TIMEOUT - 1, 1'b0, 1'b0, g);

        // reset in the middle of BUSY
        i_req = 1'b1; i_addr = 32'h300;
        step();
        step();
        check("pre_rst_busy", mem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_mem_req", mem_req, 1'b0);
        check("rst_async_mem_addr", mem_addr, '0);
        step();
        check_idle("rst_hold");
        rst = 1'b0;
        starve_m = 0;
        run_txn(2, 1'b0, 1'b0, g);
        check("after_rst_grant_i", g, 1'b1);

        // stray mem_ready in IDLE
        mem_ready = 1'b1; mem_rdata = $urandom;
        step();
        mem_ready = 1'b0;
        check_idle("idle_ready1");
        step();
        check_idle("idle_ready2");

        // randomized traffic
        for (int t = 0; t < 200; t++) begin
            if (!i_req && !d_req) begin
                for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
                    mem_ready = 1'($urandom_range(0, 1));
                    step();
                    mem_ready = 1'b0;
                    check_idle("rand_idle");
                end
                sel = $urandom_range(1, 3);
                if (sel != 2) begin i_req = 1'b1; i_addr = $urandom; end
                if (sel != 1) begin
                    d_req = 1'b1; d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom_range(0, 1));
                end
            end
            sel = $urandom_range(0, 9);
            if (sel < 7)       lat = $urandom_range(0, 4);
            else if (sel == 7) lat = TIMEOUT - 1;
            else               lat = 100;
            run_txn(lat, ($urandom_range(0, 2) != 0), 1'b1, g);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
